// File: rtl/mi_pkg.sv
// Shared RV32 decode constants and issue-queue entry type for the dual-issue front end.
package mi_pkg;

  localparam int INST_DW_DEF = 32;
  localparam int INST_AW_DEF = 32;
  localparam int QDEPTH_DEF  = 4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_MUL = 7'b0000001;

  typedef struct packed {
    logic [INST_AW_DEF-1:0] pc;
    logic [INST_DW_DEF-1:0] inst;
  } q_entry_t;

  function automatic logic is_mul(input logic [31:0] inst);
    return (inst[6:0] == OPC_OP) && (inst[31:25] == F7_MUL);
  endfunction

endpackage

// File: rtl/mi_pair_check.sv
// Purpose: decides whether H1 may issue alongside H0 (class, RAW, WAW and MUL-pair rules).
// Latency: purely combinational.
// Backpressure: none; the result only qualifies lane 1 in the issue controller.
module mi_pair_check
  import mi_pkg::*;
#(
  parameter int INST_DW = 32,
  parameter int REG_AW  = 5
) (
  input  logic [INST_DW-1:0] inst0,
  input  logic [INST_DW-1:0] inst1,
  output logic               pair_ok
);

  logic [6:0]        opc0, opc1;
  logic [REG_AW-1:0] rd0, rd1, rs1_1, rs2_1;
  logic              h0_ctrl, h1_alu, h0_wr, h1_use_rs1, h1_use_rs2;
  logic              raw, waw, mul_pair;

  assign opc0  = inst0[6:0];
  assign opc1  = inst1[6:0];
  assign rd0   = inst0[7 +: REG_AW];
  assign rd1   = inst1[7 +: REG_AW];
  assign rs1_1 = inst1[15 +: REG_AW];
  assign rs2_1 = inst1[20 +: REG_AW];

  assign h0_ctrl = (opc0 == OPC_BRANCH) || (opc0 == OPC_JAL) || (opc0 == OPC_JALR);
  assign h1_alu  = (opc1 == OPC_OP) || (opc1 == OPC_OP_IMM) ||
                   (opc1 == OPC_LUI) || (opc1 == OPC_AUIPC);

  // Unrecognised H0 opcodes are treated as writing rd, so hazards err on the safe side.
  assign h0_wr = (opc0 != OPC_BRANCH) && (opc0 != OPC_STORE) && (rd0 != '0);

  // LUI/AUIPC carry immediate bits where rs1/rs2 would sit; those must not alias a source.
  assign h1_use_rs1 = (opc1 == OPC_OP) || (opc1 == OPC_OP_IMM);
  assign h1_use_rs2 = (opc1 == OPC_OP);

  assign raw      = h0_wr && ((h1_use_rs1 && (rs1_1 == rd0)) || (h1_use_rs2 && (rs2_1 == rd0)));
  assign waw      = h0_wr && h1_alu && (rd1 == rd0);
  assign mul_pair = is_mul(inst0[31:0]) && is_mul(inst1[31:0]);

  assign pair_ok = !h0_ctrl && h1_alu && !raw && !waw && !mul_pair;

  logic unused_fields;
  assign unused_fields = ^{inst0[14:12], inst1[14:12], OPC_LOAD};

endmodule

// File: rtl/mi_issue_ctrl.sv
// Purpose: 4-entry pair queue feeding two decode lanes; optional perf counters under MI_ISSUE_PERF_EN.
// Latency: a pair accepted at edge N is presented on the issue outputs in cycle N+1.
// Backpressure: if_ready_o drops when fewer than two slots are free; stall_i holds issue, flush_i empties.
module mi_issue_ctrl
  import mi_pkg::*;
#(
  parameter int INST_DW = INST_DW_DEF,
  parameter int INST_AW = INST_AW_DEF,
  parameter int REG_AW  = 5,
  parameter int QDEPTH  = QDEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid_i,
  output logic               if_ready_o,
  input  logic [INST_AW-1:0] if_pc_i,
  input  logic [INST_DW-1:0] if_inst0_i,
  input  logic [INST_DW-1:0] if_inst1_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               iss0_valid_o,
  output logic               iss1_valid_o,
  output logic [INST_DW-1:0] iss0_inst_o,
  output logic [INST_DW-1:0] iss1_inst_o,
  output logic [INST_AW-1:0] iss0_pc_o,
  output logic [INST_AW-1:0] iss1_pc_o
`ifdef MI_ISSUE_PERF_EN
  ,
  output logic [31:0]        dual_cnt_o,
  output logic [31:0]        single_cnt_o
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  q_entry_t        q_mem [QDEPTH];
  logic [PW-1:0]   head, tail, head1, head_adv;
  logic [CW-1:0]   count, n_iss, n_enq;
  logic            enq, pair_ok;
  q_entry_t        h0, h1;

  assign head1 = head + PW'(1);
  assign h0    = q_mem[head];
  assign h1    = q_mem[head1];

  // Space check uses the registered count only; a same-cycle dequeue never frees room.
  assign if_ready_o = !rst && ((CW'(QDEPTH) - count) >= CW'(2));
  assign enq        = if_valid_i && if_ready_o && !flush_i;

  mi_pair_check #(
    .INST_DW (INST_DW),
    .REG_AW  (REG_AW)
  ) u_pair_check (
    .inst0   (h0.inst),
    .inst1   (h1.inst),
    .pair_ok (pair_ok)
  );

  assign iss0_valid_o = (count != '0) && !stall_i && !flush_i;
  assign iss1_valid_o = iss0_valid_o && (count >= CW'(2)) && pair_ok;
  assign iss0_inst_o  = h0.inst;
  assign iss0_pc_o    = h0.pc;
  assign iss1_inst_o  = h1.inst;
  assign iss1_pc_o    = h1.pc;

  assign n_iss    = CW'(iss0_valid_o) + CW'(iss1_valid_o);
  assign n_enq    = enq ? CW'(2) : '0;
  assign head_adv = iss1_valid_o ? PW'(2) : (iss0_valid_o ? PW'(1) : '0);

  always_ff @(posedge clk) begin
    if (enq) begin
      q_mem[tail]         <= '{pc: if_pc_i,               inst: if_inst0_i};
      q_mem[tail + PW'(1)] <= '{pc: if_pc_i + INST_AW'(4), inst: if_inst1_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + head_adv;
      if (enq) tail <= tail + PW'(2);
      count <= count + n_enq - n_iss;
    end
  end

`ifdef MI_ISSUE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dual_cnt_o   <= '0;
      single_cnt_o <= '0;
    end else if (iss1_valid_o) begin
      dual_cnt_o   <= dual_cnt_o + 32'd1;
    end else if (iss0_valid_o) begin
      single_cnt_o <= single_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mi_issue_ctrl.md
# mi_issue_ctrl

Dual-issue scheduler between fetch and the two decode lanes (`mi_id_0`/`mi_id_1`) of the two-issue RV32IM core. It buffers fetched instruction pairs in a 4-entry queue and decides each cycle whether to issue zero, one or two instructions. An instruction goes to lane 1 only when it is hazard-free and structurally compatible with the lane-0 instruction. It also handles pipeline flush and backend stall.

## Interface
- `INST_DW`, 32, instruction width
- `INST_AW`, 32, PC width
- `REG_AW`, 5, register address width
- `QDEPTH`, 4, queue entries (power of two, ≥2)

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `if_valid_i`  in  1  fetch pair valid
- `if_ready_o`  out  1  queue can accept a pair
- `if_pc_i`  in  INST_AW  PC of `if_inst0_i`; `if_inst1_i` is at PC+4
- `if_inst0_i`, `if_inst1_i`  in  INST_DW  fetched instructions
- `stall_i`  in  1  backend stall, no issue this cycle
- `flush_i`  in  1  redirect; discard all queued instructions
- `iss0_valid_o`, `iss1_valid_o`  out  1  lane issue valid
- `iss0_inst_o`, `iss1_inst_o`  out  INST_DW  lane instruction
- `iss0_pc_o`, `iss1_pc_o`  out  INST_AW  lane PC
- `dual_cnt_o`, `single_cnt_o`  out  32  perf counters (only with `MI_ISSUE_PERF_EN`)

## Operation
- Queue storage: circular buffer of {pc, inst}, with `head`/`tail` pointers (log2 QDEPTH bits, wrap modulo QDEPTH) and `count` (0..QDEPTH).
- Enqueue: `if_valid_i && if_ready_o && !flush_i` writes inst0 at `tail` and inst1 at `tail+1`, with PCs `if_pc_i` and `if_pc_i+4` (mod 2^INST_AW). `tail` += 2.
- `if_ready_o = !rst && (QDEPTH - count >= 2)`. It is computed from the registered count only; a same-cycle dequeue does not free space for that cycle's enqueue.
- Issue candidates: H0 = entry[head] and H1 = entry[head+1].
- `iss0_valid_o = count>=1 && !stall_i && !flush_i`.
- `iss1_valid_o = iss0_valid_o && count>=2 && pair_ok`.
- `pair_ok` is false when any of the following holds:
  - H0 is a branch, JAL or JALR.
  - H1 is not in class {OP, OP-IMM, LUI, AUIPC}.
  - RAW: H0 writes rd≠0, and H1 reads rs1 or rs2 equal to that rd. Only source fields used by H1's format count.
  - WAW: both write the same rd≠0.
  - Both H0 and H1 are MUL-class (opcode 0110011, funct7 0000001).
- Dequeue: `head` advances by the number of valid issues. `count` becomes count + 2·enq − issued.
- `flush_i` takes priority: no issue and no enqueue that cycle; next cycle `count=0` and `head=tail=0`.
- `stall_i` without flush: no dequeue. Enqueue still allowed.

## Timing
- Reset (rst high at clk edge): `count`, `head`, `tail` and the perf counters are 0. All `iss*_valid_o` are 0. `if_ready_o` is 0 while rst is high and 1 in the first cycle after.
- `iss*_inst_o`/`iss*_pc_o` are combinational reads of the registered queue. When the matching valid is low their value is don't-care.
- Latency: a pair accepted at edge N is visible on the issue outputs in cycle N+1, with no bypass.
- Full queue (count=QDEPTH): `if_ready_o=0`. With count=QDEPTH−1, `if_ready_o=0` as well.
- Reset or flush mid-operation drops every entry. No partial pair survives.

## Configuration
- `MI_ISSUE_PERF_EN` defined:
  - `dual_cnt_o` increments on each cycle with both lanes issued.
  - `single_cnt_o` increments on each cycle with only lane 0 issued.
  - Both counters are 32-bit, wrap at 2^32−1→0, and clear on rst.
- `MI_ISSUE_PERF_EN` undefined: counter registers and ports are absent.

## Structure
- Shared package `mi_pkg`: RV32 opcode constants (OP, OP-IMM, LUI, AUIPC, BRANCH, JAL, JALR, LOAD, STORE), MUL funct7, `QDEPTH` default, and the queue entry struct {pc, inst}.
- Sub-module `mi_pair_check`: purely combinational decode of H0/H1 classes, rd/rs fields, and the `pair_ok` output.

## Test plan
- Reset, then the pair `addi x1,x0,1` / `addi x2,x0,2` at PC 0x0 → cycle after enqueue: both valid, PCs 0x0/0x4, dual_cnt=1.
- RAW pair `addi x1,x0,5` / `add x3,x1,x1` → cycle 1: lane 0 only; cycle 2: lane 0 issues `add` at PC+4.
- `mul x1,x2,x3` / `mul x4,x5,x6` → single, then single. Paired with `add x7,x0,x0` instead → dual.
- Enqueue 2 pairs under `stall_i=1` → count=4, `if_ready_o=0`. Release stall → dual issue and `if_ready_o=1` next cycle. Pointers wrap 3→0 correctly.
- `beq` in H0 with valid H1 → lane 1 not issued. `lw` in H1 → lane 1 not issued.
- `flush_i` with count=3 and `if_valid_i=1` → no issue that cycle; next cycle count=0 and all valids low. Enqueue resumes the following cycle.
